mips_multicycle_ctrl: RTL and testbench

- Moore-FSM control unit that sequences the multi-cycle variant of the MIPS datapath: one shared memory for instructions and data, plus IR, A/B, ALUOut and Data registers.
- Decodes opcode/funct and drives every datapath enable and mux select, state by state.
- Stalls on a memory-ready handshake, flags illegal instructions and counts retired instructions.

---
 rtl/mips_multicycle_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Moore-style control unit for the multi-cycle MIPS datapath (shared
// instruction/data memory, IR, A/B, ALUOut and Data registers).
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   opcode, funct     IR[31:26] and IR[5:0]
//   zero              ALU zero flag (branch compare)
//   mem_ready         memory finished the current access this cycle
//   pc_en .. pc_src   datapath enables and mux selects
//   illegal           sticky illegal-instruction flag (cleared by rst only)
//   retired           completed-instruction counter, wraps
//   state_dbg         current state encoding
module mips_multicycle_ctrl #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_en,
  output logic                 iord,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [2:0]           alu_control,
  output logic [1:0]           pc_src,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] retired,
  output logic [3:0]           state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t                 state_q, state_d;
  logic                   illegal_q, illegal_d;
  logic [CNT_WIDTH-1:0]   retired_q, retired_d;
  // Remembers lw vs sw from DECODE so MEMADR does not re-read the opcode.
  logic                   is_store_q, is_store_d;
  logic                   retire;
  logic                   funct_ok;

  always_comb begin
    unique case (funct)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_ok = 1'b1;
      default:                                              funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    is_store_d  = is_store_q;
    retire      = 1'b0;
    pc_en       = 1'b0;
    iord        = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = 3'b010;
    pc_src      = 2'b00;

    case (state_q)
      S_FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW: begin
            state_d    = S_MEMADR;
            is_store_d = 1'b0;
          end
          OP_SW: begin
            state_d    = S_MEMADR;
            is_store_d = 1'b1;
          end
          OP_RTYPE: begin
            if (funct_ok) begin
              state_d = S_EXEC;
            end else begin
              state_d   = S_FETCH;
              illegal_d = 1'b1;
            end
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_ADDI: state_d = S_ADDIEX;
          OP_J:    state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = is_store_q ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        unique case (funct)
          6'b100010: alu_control = 3'b110;
          6'b100100: alu_control = 3'b000;
          6'b100101: alu_control = 3'b001;
          6'b101010: alu_control = 3'b111;
          default:   alu_control = 3'b010;
        endcase
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = 3'b110;
        pc_src      = 2'b01;
        pc_en       = zero;
        state_d     = S_FETCH;
        retire      = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_JUMP: begin
        pc_src  = 2'b10;
        pc_en   = 1'b1;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    retired_d = retire ? retired_q + CNT_WIDTH'(1) : retired_q;

    // Architectural-state writes are suppressed during the reset cycle.
    if (rst) begin
      pc_en     = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      illegal_q  <= 1'b0;
      retired_q  <= '0;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      illegal_q  <= illegal_d;
      retired_q  <= retired_d;
      is_store_q <= is_store_d;
    end
  end

  assign illegal   = illegal_q;
  assign retired   = retired_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl. Instructions are expanded
// into their expected state walk (including memory wait cycles) and every
// cycle's outputs are compared against the per-state control table.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic       illegal;
  logic [3:0] retired;
  logic [3:0] state_dbg;
  logic [14:0] ctrl_vec;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned retired_m = 0;
  logic        illegal_m = 1'b0;

  mips_multicycle_ctrl #(.CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .pc_src(pc_src), .illegal(illegal),
    .retired(retired), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  assign ctrl_vec = {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg,
                     reg_write, alu_src_a, alu_src_b, alu_control, pc_src};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic bit funct_legal(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  // Control table straight from the state descriptions.
  function automatic logic [14:0] exp_ctrl(input int st, input logic [5:0] fn,
                                           input logic mr, input logic z, input logic r);
    logic pe, io, mw, irw, rd, m2r, rw, asa;
    logic [1:0] asb, pcs;
    logic [2:0] alu;
    {pe, io, mw, irw, rd, m2r, rw, asa} = '0;
    asb = 2'b00; pcs = 2'b00; alu = 3'b010;
    case (st)
      0:  begin asb = 2'b01; irw = mr; pe = mr; end
      1:  asb = 2'b11;
      2:  begin asa = 1'b1; asb = 2'b10; end
      3:  io = 1'b1;
      4:  begin m2r = 1'b1; rw = 1'b1; end
      5:  begin io = 1'b1; mw = 1'b1; end
      6:  begin asa = 1'b1; alu = alu_of(fn); end
      7:  begin rd = 1'b1; rw = 1'b1; end
      8:  begin asa = 1'b1; alu = 3'b110; pcs = 2'b01; pe = z; end
      9:  begin asa = 1'b1; asb = 2'b10; end
      10: rw = 1'b1;
      11: begin pcs = 2'b10; pe = 1'b1; end
      default: ;
    endcase
    if (r) begin pe = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0; end
    return {pe, io, mw, irw, rd, m2r, rw, asa, asb, alu, pcs};
  endfunction

  task automatic step(input int st, input logic [5:0] fn, input logic mr,
                      input logic z, input logic r);
    mem_ready = mr; zero = z; rst = r;
    @(negedge clk);
    chk($sformatf("state@s%0d", st), 32'(state_dbg), 32'(st));
    chk($sformatf("ctrl@s%0d", st), 32'(ctrl_vec), 32'(exp_ctrl(st, fn, mr, z, r)));
    chk($sformatf("retired@s%0d", st), 32'(retired), retired_m % 16);
    chk($sformatf("illegal@s%0d", st), 32'(illegal), 32'(illegal_m));
    @(posedge clk); #1;
  endtask

  // rst_at: -1 none, -2 random cycle, else index of the cycle to reset in.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int wf, input int wm, input logic z, input int rst_at);
    int seq[$];
    bit mrs[$];
    bit bad;
    int ra;
    bad = 1'b0;
    for (int i = 0; i < wf; i++) begin seq.push_back(0); mrs.push_back(1'b0); end
    seq.push_back(0); mrs.push_back(1'b1);
    seq.push_back(1); mrs.push_back(1'($urandom));
    case (op)
      6'b100011: begin
        seq.push_back(2); mrs.push_back(1'($urandom));
        for (int i = 0; i < wm; i++) begin seq.push_back(3); mrs.push_back(1'b0); end
        seq.push_back(3); mrs.push_back(1'b1);
        seq.push_back(4); mrs.push_back(1'($urandom));
      end
      6'b101011: begin
        seq.push_back(2); mrs.push_back(1'($urandom));
        for (int i = 0; i < wm; i++) begin seq.push_back(5); mrs.push_back(1'b0); end
        seq.push_back(5); mrs.push_back(1'b1);
      end
      6'b000000: begin
        if (funct_legal(fn)) begin
          seq.push_back(6); mrs.push_back(1'($urandom));
          seq.push_back(7); mrs.push_back(1'($urandom));
        end else bad = 1'b1;
      end
      6'b000100: begin seq.push_back(8); mrs.push_back(1'($urandom)); end
      6'b001000: begin
        seq.push_back(9);  mrs.push_back(1'($urandom));
        seq.push_back(10); mrs.push_back(1'($urandom));
      end
      6'b000010: begin seq.push_back(11); mrs.push_back(1'($urandom)); end
      default: bad = 1'b1;
    endcase
    ra = (rst_at == -2) ? int'($urandom_range(0, seq.size() - 1)) : rst_at;
    for (int i = 0; i < seq.size(); i++) begin
      // Instruction fields are only meaningful in DECODE/EXEC; scramble otherwise.
      opcode = (seq[i] == 1) ? op : 6'($urandom);
      funct  = (seq[i] == 1 || seq[i] == 6) ? fn : 6'($urandom);
      step(seq[i], fn, mrs[i], (seq[i] == 8) ? z : 1'($urandom), i == ra);
      if (i == ra) begin
        retired_m = 0;
        illegal_m = 1'b0;
        return;
      end
      if (seq[i] == 1 && bad) illegal_m = 1'b1;
    end
    if (!bad) retired_m++;
  endtask

  initial begin
    logic [5:0] ops[8];
    logic [5:0] fns[6];
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
            6'b001000, 6'b000010, 6'b111111, 6'b010101};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};

    rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    step(0, 6'b0, 1'b1, 1'b0, 1'b1);            // reset state, enables forced low
    step(0, 6'b0, 1'b0, 1'b0, 1'b0);            // hold in FETCH without mem_ready
    retired_m = 0; illegal_m = 1'b0;

    run_instr(6'b000000, 6'b100010, 0, 0, 1'b0, 2);  // reset mid-EXEC
    run_instr(6'b100011, 6'b0, 0, 0, 1'b0, -1);       // lw, 5 cycles
    run_instr(6'b101011, 6'b0, 0, 2, 1'b0, -1);       // sw, 2 waits in MEMWR
    run_instr(6'b000000, 6'b100010, 0, 0, 1'b0, -1);  // sub
    run_instr(6'b000000, 6'b101010, 1, 0, 1'b0, -1);  // slt, fetch wait
    run_instr(6'b000100, 6'b0, 0, 0, 1'b0, -1);       // beq not taken
    run_instr(6'b000100, 6'b0, 0, 0, 1'b1, -1);       // beq taken
    run_instr(6'b111111, 6'b0, 0, 0, 1'b0, -1);       // illegal opcode
    run_instr(6'b000000, 6'b000000, 0, 0, 1'b0, -1);  // illegal funct
    run_instr(6'b000010, 6'b0, 0, 0, 1'b0, -1);       // j after illegal
    run_instr(6'b001000, 6'b0, 0, 0, 1'b0, -1);       // addi
    run_instr(6'b100011, 6'b0, 2, 3, 1'b0, -1);       // lw with waits
    run_instr(6'b000000, 6'b100000, 0, 0, 1'b0, 3);   // reset in ALUWB
    run_instr(6'b101011, 6'b0, 0, 1, 1'b0, 3);        // reset in MEMWR wait
    run_instr(6'b100011, 6'b0, 0, 0, 1'b0, 0);        // reset in FETCH, mem_ready=1
    for (int i = 0; i < 20; i++)                      // counter wrap
      run_instr(6'b000010, 6'b0, 0, 0, 1'b0, -1);

    for (int i = 0; i < 80; i++) begin
      run_instr(ops[$urandom_range(0, 7)], fns[$urandom_range(0, 5)],
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                1'($urandom), ($urandom_range(0, 19) == 0) ? -2 : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
